cal_bin2bcd: RTL and testbench

- Downstream stage of the 4-bit calculator datapath.
- Consumes the binary result of the adder, subtractor or multiplier (8-bit product width) and converts it to packed BCD for the display driver.
- Sequential double-dabble engine: one bit per clock, valid/ready handshakes on both sides.

---
 rtl/cal_pkg.sv | 30 +++
 rtl/cal_bcd_adj.sv | 19 +
 rtl/cal_bin2bcd.sv | 139 +++++++++++++
 tb/tb_cal_bin2bcd.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared types and constants for the calculator BCD conversion stage.
package cal_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } cal_state_e;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

   // Smallest digit count d with 10**d > 2**in_w.
   function automatic int unsigned bcd_min_digits(input int unsigned in_w);
      longint unsigned lim;
      longint unsigned pow;
      int unsigned     d;
      lim = 64'd1 << in_w;
      pow = 64'd1;
      d   = 32'd0;
      for (int i = 0; i < 20; i++) begin
         if (pow <= lim) begin
            pow = pow * 64'd10;
            d   = d + 32'd1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/cal_bcd_adj.sv
// Single BCD digit add-3 corrector used before each double-dabble shift.
module cal_bcd_adj
   import cal_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adj_digit
);

   // Digits of 5 or more get +3 so the following shift carries correctly.
   always_comb begin
      adj_digit = digit;
      if (digit >= BCD_ADJ_THRESH) begin
         adj_digit = digit + BCD_ADJ_ADD;
      end else begin
         adj_digit = digit;
      end
   end

endmodule

// File: rtl/cal_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional CAL_BCD_SIGN_EN treats in_bin as two's complement and adds out_neg.
module cal_bin2bcd
   import cal_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
`ifdef CAL_BCD_SIGN_EN
   output logic                  out_neg,
`endif
   output logic                  busy
);

   localparam int BW         = 4 * DIGITS;
   localparam int CW         = $clog2(IN_W + 1);
   localparam int MIN_DIGITS = int'(bcd_min_digits(IN_W));

   if (DIGITS < MIN_DIGITS) begin : g_digits_check
      $error("cal_bin2bcd: DIGITS too small for IN_W");
   end

   cal_state_e          state_r;
   cal_state_e          state_nx;
   logic [IN_W-1:0]     bin_r;
   logic [BW-1:0]       bcd_r;
   logic [CW-1:0]       count_r;
   logic [BW-1:0]       adj_s;
   logic [BW+IN_W-1:0]  shifted_s;
   logic [IN_W-1:0]     load_bin_s;
   logic                accept_s;
   logic                in_ready_r;
   logic                out_valid_r;
   logic                busy_r;
   logic [BW-1:0]       out_bcd_r;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      cal_bcd_adj u_adj (
         .digit     (bcd_r[4*g +: 4]),
         .adj_digit (adj_s[4*g +: 4])
      );
   end

   assign shifted_s = {adj_s, bin_r} << 1;
   assign accept_s  = in_valid && in_ready_r;

`ifdef CAL_BCD_SIGN_EN
   logic neg_r;
   logic out_neg_r;
   // Negative inputs are latched as their IN_W-bit magnitude.
   assign load_bin_s = in_bin[IN_W-1] ? (~in_bin + {{(IN_W-1){1'b0}}, 1'b1}) : in_bin;
   assign out_neg    = out_neg_r;
`else
   assign load_bin_s = in_bin;
`endif

   // Next-state decode for the IDLE -> SHIFT -> DONE sequence.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nx = SHIFT;
            else          state_nx = IDLE;
         end
         SHIFT: begin
            if (count_r == CW'(1)) state_nx = DONE;
            else                   state_nx = SHIFT;
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
            else           state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, handshake flags and the shift datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         bin_r       <= '0;
         bcd_r       <= '0;
         count_r     <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_bcd_r   <= '0;
`ifdef CAL_BCD_SIGN_EN
         neg_r       <= 1'b0;
         out_neg_r   <= 1'b0;
`endif
      end else begin
         state_r     <= state_nx;
         in_ready_r  <= (state_nx == IDLE);
         out_valid_r <= (state_nx == DONE);
         busy_r      <= (state_nx != IDLE);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  bin_r   <= load_bin_s;
                  bcd_r   <= '0;
                  count_r <= CW'(IN_W);
`ifdef CAL_BCD_SIGN_EN
                  neg_r   <= in_bin[IN_W-1];
`endif
               end
            end
            SHIFT: begin
               bcd_r   <= shifted_s[BW+IN_W-1:IN_W];
               bin_r   <= shifted_s[IN_W-1:0];
               count_r <= count_r - CW'(1);
               // Only the final shift result is published.
               if (count_r == CW'(1)) begin
                  out_bcd_r <= shifted_s[BW+IN_W-1:IN_W];
`ifdef CAL_BCD_SIGN_EN
                  out_neg_r <= neg_r;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_bcd   = out_bcd_r;

endmodule

// File: tb/tb_cal_bin2bcd.sv
// Self-checking bench for cal_bin2bcd: directed cases plus random values
// compared against an arithmetic decimal-digit model.
module tb_cal_bin2bcd;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_bin;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_bcd;
   logic        busy;
`ifdef CAL_BCD_SIGN_EN
   logic        out_neg;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   cal_bin2bcd #(.IN_W(8), .DIGITS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
`ifdef CAL_BCD_SIGN_EN
      .out_neg   (out_neg),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt = total_cnt + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic int mag_of(input logic [7:0] v);
      int s;
`ifdef CAL_BCD_SIGN_EN
      s = v[7] ? int'(v) - 256 : int'(v);
`else
      s = int'(v);
`endif
      return (s < 0) ? -s : s;
   endfunction

   function automatic logic [11:0] exp_bcd(input logic [7:0] v);
      int m;
      m = mag_of(v);
      return 12'((m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10));
   endfunction

   // Present v with in_ready expected high; returns at the negedge after the accept edge.
   task automatic start(input logic [7:0] v);
      chk("ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_bin   = v;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count cycles to out_valid and check the result and latency.
   task automatic wait_result(input logic [7:0] v, input string tag);
      int   k;
      logic ready_seen;
      k = 0;
      ready_seen = 1'b0;
      while (!out_valid && k < 40) begin
         if (in_ready || !busy) ready_seen = 1'b1;
         @(negedge clk);
         k++;
      end
      chk({tag, "_latency"}, 32'(k), 32'd8);
      chk({tag, "_ready_low_in_shift"}, 32'(ready_seen), 32'd0);
      chk({tag, "_bcd"}, 32'(out_bcd), 32'(exp_bcd(v)));
      chk({tag, "_busy_done"}, 32'(busy), 32'd1);
      chk({tag, "_ready_done"}, 32'(in_ready), 32'd0);
`ifdef CAL_BCD_SIGN_EN
      chk({tag, "_neg"}, 32'(out_neg), 32'(v[7]));
`endif
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [7:0]  v;
      logic [11:0] held;
      int          hold;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bin    = 8'd0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_bcd", 32'(out_bcd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Zero and maximum input.
      start(8'h00);
      wait_result(8'h00, "zero");
      handshake("zero");
      start(8'hFF);
      wait_result(8'hFF, "max");
      handshake("max");

      // Back-pressure, with a competing request held during DONE.
      start(8'd99);
      wait_result(8'd99, "bp99");
      held     = out_bcd;
      in_valid = 1'b1;
      in_bin   = 8'd33;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_held", 32'(out_valid), 32'd1);
         chk("bp_bcd_stable", 32'(out_bcd), 32'(held));
         chk("bp_ready_low", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle_after_hs", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_second_accepted", 32'(in_ready), 32'd0);
      wait_result(8'd33, "bp33");
      handshake("bp33");

      // Back-to-back with out_ready held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_bin    = 8'd15;
      @(negedge clk);
      chk("b2b_first_accepted", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      wait_result(8'd15, "b2b15");
      in_valid  = 1'b1;
      in_bin    = 8'd240;
      @(negedge clk);
      chk("b2b_hs_ready", 32'(in_ready), 32'd1);
      chk("b2b_hs_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid  = 1'b0;
      chk("b2b_second_accepted", 32'(in_ready), 32'd0);
      out_ready = 1'b0;
      wait_result(8'd240, "b2b240");
      handshake("b2b240");

      // Asynchronous reset during the shift of 200.
      start(8'd200);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_bcd", 32'(out_bcd), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start(8'd7);
      wait_result(8'd7, "after_rst");
      handshake("after_rst");

`ifdef CAL_BCD_SIGN_EN
      start(8'hF6);
      wait_result(8'hF6, "neg10");
      chk("neg10_bcd_abs", 32'(out_bcd), 32'h010);
      handshake("neg10");
      start(8'h80);
      wait_result(8'h80, "neg128");
      chk("neg128_bcd_abs", 32'(out_bcd), 32'h128);
      handshake("neg128");
`endif

      // Random values with random back-pressure.
      for (int n = 0; n < 20; n++) begin
         v    = 8'($urandom_range(255, 0));
         hold = int'($urandom_range(3, 0));
         start(v);
         wait_result(v, "rand");
         held = out_bcd;
         repeat (hold) @(negedge clk);
         chk("rand_bcd_held", 32'(out_bcd), 32'(held));
         handshake("rand");
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
